// File: rtl/gol_if.sv
// Control/status bundle between the user-input logic (master) and the Game of Life core (slave).
// The core drives the cell grid and its generation counter and flags back to the master.
interface gol_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                 edit_en;
    logic [RW-1:0]        edit_row;
    logic [CW-1:0]        edit_col;
    logic                 edit_val;
    logic                 run;
    logic                 step;
    logic                 clear;
    logic [ROWS*COLS-1:0] grid;
    logic [GEN_W-1:0]     generation;
    logic                 running;
    logic                 stable;
    logic                 extinct;

    modport master (
        output edit_en, edit_row, edit_col, edit_val, run, step, clear,
        input  grid, generation, running, stable, extinct
    );

    modport slave (
        input  edit_en, edit_row, edit_col, edit_val, run, step, clear,
        output grid, generation, running, stable, extinct
    );
endinterface

// File: rtl/gol_engine.sv
// Conway Game of Life core: editable ROWS x COLS grid with step/run/pause/clear,
// optional toroidal wrap, generation counter and still-life/extinction halt.
module gol_engine #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter bit WRAP     = 1'b0,
    parameter int TICK_DIV = 8,
    parameter int GEN_W    = 16
) (
    input  logic  clk,
    input  logic  reset_n,
    gol_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_EDIT, S_RUN, S_HALT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;
    logic [N-1:0]     next_grid;
    logic             commit;

    // Off-grid neighbours either wrap around the torus or read as dead.
    function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
        int rr;
        int cc;
        if (WRAP) begin
            rr = (r + ROWS) % ROWS;
            cc = (c + COLS) % COLS;
        end else begin
            if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
            rr = r;
            cc = c;
        end
        return g[IW'(rr * COLS + cc)];
    endfunction

    always_comb begin
        logic [3:0] n;
        logic       alive;
        next_grid = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) n = n + {3'b000, cell_at(grid_q, r + dr, c + dc)};
                    end
                end
                alive = grid_q[IW'(r * COLS + c)];
                next_grid[IW'(r * COLS + c)] = (n == 4'd3) || (alive && n == 4'd2);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        tick_d    = tick_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        commit    = 1'b0;

        if (bus.clear) begin
            state_d   = S_EDIT;
            grid_d    = '0;
            gen_d     = '0;
            tick_d    = '0;
            stable_d  = 1'b0;
            extinct_d = 1'b0;
        end else begin
            case (state_q)
                S_EDIT: begin
                    if (bus.edit_en && int'(bus.edit_row) < ROWS && int'(bus.edit_col) < COLS)
                        grid_d[IW'(int'(bus.edit_row) * COLS + int'(bus.edit_col))] = bus.edit_val;
                    if (bus.run) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                    end else if (bus.step && !bus.edit_en) begin
                        commit = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.run) begin
                        state_d = S_EDIT;
                        tick_d  = '0;
                    end else if (tick_q == TICK_LAST) begin
                        commit = 1'b1;
                        tick_d = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_HALT: begin
                    if (!bus.run) state_d = S_EDIT;
                end
                default: state_d = S_EDIT;
            endcase
        end

        if (commit) begin
            grid_d    = next_grid;
            gen_d     = (gen_q == '1) ? gen_q : gen_q + 1'b1;
            stable_d  = (next_grid == grid_q);
            extinct_d = (next_grid == '0);
            if (state_q == S_RUN && (stable_d || extinct_d)) state_d = S_HALT;
        end
    end

    // NOTE: the grid is plain flops rather than RAM, so it resets asynchronously with the rest of the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_EDIT;
            grid_q    <= '0;
            gen_q     <= '0;
            tick_q    <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            tick_q    <= tick_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign bus.grid       = grid_q;
    assign bus.generation = gen_q;
    assign bus.running    = (state_q == S_RUN);
    assign bus.stable     = stable_q;
    assign bus.extinct    = extinct_q;
endmodule
